pixel_rgb_stream_mapper: RTL and testbench

//  Streaming converter: single-channel pixels (binary/grayscale) -> RGB, with frame geometry tracking.

---
 rtl/pixel_rgb_pkg.sv | 18 +
 rtl/pixel_rgb_stream_mapper_if.sv | 42 ++++
 rtl/pixel_colour_map.sv | 73 +++++++
 rtl/pixel_rgb_stream_mapper.sv | 163 ++++++++++++++++
 tb/tb_pixel_rgb_stream_mapper.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_rgb_pkg.sv
// Shared definitions for the pixel -> RGB stream mapper.
//   MODE_*      : colour-map mode encoding carried on the 2-bit mode input
//   RGB_*_SLOT  : channel slot inside a packed {r,g,b} word (slot * PIX_W = LSB)
package pixel_rgb_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_GRAY   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BINARY = 2'd1;
    localparam logic [MODE_W-1:0] MODE_INVERT = 2'd2;
    localparam logic [MODE_W-1:0] MODE_HEAT   = 2'd3;

    // Packed colour words are {r,g,b}: r in the top slot, b in the bottom slot.
    localparam int unsigned RGB_R_SLOT = 2;
    localparam int unsigned RGB_G_SLOT = 1;
    localparam int unsigned RGB_B_SLOT = 0;

endpackage

// File: rtl/pixel_rgb_stream_mapper_if.sv
// Stream bundle for the pixel -> RGB mapper.
//   in_valid/in_ready/in_pixel/in_sof       : single-channel pixel stream into the mapper
//   out_valid/out_ready/out_r/out_g/out_b   : RGB beat stream out of the mapper
//   out_col/out_row/out_sof/out_eol/out_eof : frame position and framing flags of the beat
// Modports: slave = mapper side, master = source/sink side.
interface pixel_rgb_stream_mapper_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 10,
    parameter int unsigned IMG_H = 10
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;

    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_r;
    logic [PIX_W-1:0] out_g;
    logic [PIX_W-1:0] out_b;
    logic [CW-1:0]    out_col;
    logic [RW-1:0]    out_row;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b,
        output out_col, out_row, out_sof, out_eol, out_eof
    );

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b,
        input  out_col, out_row, out_sof, out_eol, out_eof
    );

endinterface

// File: rtl/pixel_colour_map.sv
// Combinational colour map: one PIX_W pixel -> packed {r,g,b}.
//   pixel     : input sample
//   mode      : GRAY / BINARY / INVERT / HEAT
//   threshold : BINARY compare level (pixel >= threshold selects fg_rgb)
//   fg_rgb    : BINARY foreground colour {r,g,b}
//   bg_rgb    : BINARY background colour {r,g,b}
//   rgb       : mapped colour {r,g,b}
module pixel_colour_map
    import pixel_rgb_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [PIX_W-1:0]   pixel,
    input  logic [MODE_W-1:0]  mode,
    input  logic [PIX_W-1:0]   threshold,
    input  logic [3*PIX_W-1:0] fg_rgb,
    input  logic [3*PIX_W-1:0] bg_rgb,
    output logic [3*PIX_W-1:0] rgb
);

    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic [PIX_W-1:0] two_d;

    always_comb begin
        r   = '0;
        g   = '0;
        b   = '0;
        rgb = '0;
        // 2*(p mod H): below H this is 2p, at/above H it is 2(p-H). Never overflows PIX_W.
        two_d = {pixel[PIX_W-2:0], 1'b0};

        case (mode)
            MODE_GRAY: begin
                r = pixel;
                g = pixel;
                b = pixel;
            end
            MODE_INVERT: begin
                // M - p == bitwise complement for M = 2^PIX_W - 1
                r = ~pixel;
                g = ~pixel;
                b = ~pixel;
            end
            MODE_HEAT: begin
                if (!pixel[PIX_W-1]) begin
                    r = '0;
                    g = two_d;
                    b = ~two_d;
                end else begin
                    r = two_d | PIX_W'(1);
                    g = ~two_d;
                    b = '0;
                end
            end
            default: begin
                r = '0;
                g = '0;
                b = '0;
            end
        endcase

        rgb[RGB_R_SLOT*PIX_W +: PIX_W] = r;
        rgb[RGB_G_SLOT*PIX_W +: PIX_W] = g;
        rgb[RGB_B_SLOT*PIX_W +: PIX_W] = b;

        if (mode == MODE_BINARY) begin
            rgb = (pixel >= threshold) ? fg_rgb : bg_rgb;
        end
    end

endmodule

// File: rtl/pixel_rgb_stream_mapper.sv
// Streaming single-channel pixel -> RGB converter with frame geometry tracking.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   stream     : slave side of the pixel/RGB stream bundle (handshake, data, position, flags)
//   mode       : colour-map mode, sampled only at frame start
//   threshold  : BINARY threshold, sampled only at frame start
//   fg_rgb     : BINARY foreground {r,g,b}, sampled only at frame start
//   bg_rgb     : BINARY background {r,g,b}, sampled only at frame start
//   sync_err   : one-cycle pulse, issued with the beat of a pixel whose in_sof disagrees
//                with the tracked position
// Single output register stage; in_ready is combinational so full rate has no bubbles.
module pixel_rgb_stream_mapper
    import pixel_rgb_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 10,
    parameter int unsigned IMG_H = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_rgb_stream_mapper_if.slave stream,
    input  logic [MODE_W-1:0]    mode,
    input  logic [PIX_W-1:0]     threshold,
    input  logic [3*PIX_W-1:0]   fg_rgb,
    input  logic [3*PIX_W-1:0]   bg_rgb,
    output logic                 sync_err
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Position of the next pixel to be accepted
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Per-frame configuration shadow
    logic [MODE_W-1:0]  cfg_mode_q;
    logic [PIX_W-1:0]   cfg_thr_q;
    logic [3*PIX_W-1:0] cfg_fg_q;
    logic [3*PIX_W-1:0] cfg_bg_q;

    // Output register
    logic               out_valid_q;
    logic [3*PIX_W-1:0] out_rgb_q;
    logic [CW-1:0]      out_col_q;
    logic [RW-1:0]      out_row_q;
    logic               out_sof_q;
    logic               out_eol_q;
    logic               out_eof_q;
    logic               sync_err_q;

    logic               accept;
    logic               at_origin;
    logic               frame_start;
    logic               pos_err;
    logic [CW-1:0]      eff_col;
    logic [RW-1:0]      eff_row;
    logic               last_col;
    logic               last_row;
    logic [MODE_W-1:0]  map_mode;
    logic [PIX_W-1:0]   map_thr;
    logic [3*PIX_W-1:0] map_fg;
    logic [3*PIX_W-1:0] map_bg;
    logic [3*PIX_W-1:0] map_rgb;

    assign stream.in_ready = !out_valid_q || stream.out_ready;
    assign accept          = stream.in_valid && stream.in_ready;

    always_comb begin
        at_origin   = (col_q == '0) && (row_q == '0);
        // in_sof anywhere forces this pixel to (0,0); a missing in_sof at (0,0) is still (0,0).
        frame_start = at_origin || stream.in_sof;
        pos_err     = stream.in_sof != at_origin;

        eff_col  = frame_start ? '0 : col_q;
        eff_row  = frame_start ? '0 : row_q;
        last_col = eff_col == COL_LAST;
        last_row = eff_row == ROW_LAST;

        // Continue counting from the effective position, so a resync resumes at column 1.
        col_d = last_col ? '0 : eff_col + CW'(1);
        row_d = eff_row;
        if (last_col) begin
            row_d = last_row ? '0 : eff_row + RW'(1);
        end

        // The frame-start pixel already uses the configuration it captures.
        map_mode = frame_start ? mode      : cfg_mode_q;
        map_thr  = frame_start ? threshold : cfg_thr_q;
        map_fg   = frame_start ? fg_rgb    : cfg_fg_q;
        map_bg   = frame_start ? bg_rgb    : cfg_bg_q;
    end

    pixel_colour_map #(
        .PIX_W (PIX_W)
    ) u_colour_map (
        .pixel     (stream.in_pixel),
        .mode      (map_mode),
        .threshold (map_thr),
        .fg_rgb    (map_fg),
        .bg_rgb    (map_bg),
        .rgb       (map_rgb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            cfg_mode_q <= MODE_GRAY;
            cfg_thr_q  <= '0;
            cfg_fg_q   <= '0;
            cfg_bg_q   <= '0;
        end else if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            if (frame_start) begin
                cfg_mode_q <= mode;
                cfg_thr_q  <= threshold;
                cfg_fg_q   <= fg_rgb;
                cfg_bg_q   <= bg_rgb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            sync_err_q <= accept && pos_err;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_rgb_q   <= map_rgb;
                out_col_q   <= eff_col;
                out_row_q   <= eff_row;
                out_sof_q   <= frame_start;
                out_eol_q   <= last_col;
                out_eof_q   <= last_col && last_row;
            end else if (stream.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_r     = out_rgb_q[RGB_R_SLOT*PIX_W +: PIX_W];
    assign stream.out_g     = out_rgb_q[RGB_G_SLOT*PIX_W +: PIX_W];
    assign stream.out_b     = out_rgb_q[RGB_B_SLOT*PIX_W +: PIX_W];
    assign stream.out_col   = out_col_q;
    assign stream.out_row   = out_row_q;
    assign stream.out_sof   = out_sof_q;
    assign stream.out_eol   = out_eol_q;
    assign stream.out_eof   = out_eof_q;
    assign sync_err         = sync_err_q;

endmodule

// File: tb/tb_pixel_rgb_stream_mapper.sv
// Self-checking bench for pixel_rgb_stream_mapper: a frame-index model predicts every
// beat; directed literal checks pin the model and the key boundary cases.
module tb_pixel_rgb_stream_mapper;

    localparam int PIX_W = 8;
    localparam int IMG_W = 10;
    localparam int IMG_H = 10;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic [23:0] fg_rgb;
    logic [23:0] bg_rgb;
    logic        sync_err;
    bit          stall_en = 1'b0;

    always #5 clk = ~clk;

    pixel_rgb_stream_mapper_if #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    pixel_rgb_stream_mapper #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (bus),
        .mode      (mode),
        .threshold (threshold),
        .fg_rgb    (fg_rgb),
        .bg_rgb    (bg_rgb),
        .sync_err  (sync_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [23:0] rgb;
        int          col;
        int          row;
        logic        sof;
        logic        eol;
        logic        eof;
        logic        serr;
        bit          shown;
    } beat_t;

    beat_t       q[$];
    int          idx;
    int          popped;
    logic [1:0]  m_mode;
    int          m_thr;
    logic [23:0] m_fg;
    logic [23:0] m_bg;

    function automatic logic [23:0] model_map(input int p, input logic [1:0] md, input int thr,
                                              input logic [23:0] fg, input logic [23:0] bg);
        int h, mx, r, g, b;
        h  = 1 << (PIX_W - 1);
        mx = (1 << PIX_W) - 1;
        r = 0; g = 0; b = 0;
        case (md)
            2'd0: begin r = p; g = p; b = p; end
            2'd1: return (p >= thr) ? fg : bg;
            2'd2: begin r = mx - p; g = mx - p; b = mx - p; end
            default: begin
                if (p < h) begin
                    r = 0; g = 2 * p; b = mx - 2 * p;
                end else begin
                    r = (2 * (p - h)) | 1; g = mx - 2 * (p - h); b = 0;
                end
            end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Compare process: inputs change 1 time unit after posedge, so negedge sees the
    // settled values that the next posedge will act on.
    always @(negedge clk) begin
        beat_t bt;
        bit    exp_valid;
        int    eff;
        bit    origin;
        if (rst) begin
            q.delete();
            idx    = 0;
            m_mode = 2'd0;
            m_thr  = 0;
            m_fg   = 24'h0;
            m_bg   = 24'h0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_sync_err", sync_err, 0);
        end else begin
            exp_valid = q.size() > 0;
            check("out_valid", bus.out_valid, exp_valid);
            check("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
            if (exp_valid && bus.out_valid) begin
                bt = q[0];
                check("rgb", {bus.out_r, bus.out_g, bus.out_b}, bt.rgb);
                check("col", bus.out_col, bt.col);
                check("row", bus.out_row, bt.row);
                check("sof", bus.out_sof, bt.sof);
                check("eol", bus.out_eol, bt.eol);
                check("eof", bus.out_eof, bt.eof);
                check("sync_err", sync_err, bt.shown ? 1'b0 : bt.serr);
                q[0].shown = 1'b1;
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
            end else begin
                check("sync_err_idle", sync_err, 0);
            end
            if (bus.in_valid && bus.in_ready) begin
                origin = (idx == 0) || bus.in_sof;
                eff    = origin ? 0 : idx;
                if (origin) begin
                    m_mode = mode;
                    m_thr  = threshold;
                    m_fg   = fg_rgb;
                    m_bg   = bg_rgb;
                end
                bt.rgb   = model_map(bus.in_pixel, m_mode, m_thr, m_fg, m_bg);
                bt.col   = eff % IMG_W;
                bt.row   = eff / IMG_W;
                bt.sof   = eff == 0;
                bt.eol   = (eff % IMG_W) == IMG_W - 1;
                bt.eof   = eff == NPIX - 1;
                bt.serr  = bus.in_sof != (idx == 0);
                bt.shown = 1'b0;
                q.push_back(bt);
                idx = (eff + 1) % NPIX;
            end
        end
    end

    // Downstream sink: always ready unless random stalling is enabled
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] p, input logic s);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        bus.in_sof   = s;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (q.size() > 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  heat_p[4]   = '{8'd0, 8'd127, 8'd128, 8'd255};
    logic [23:0] heat_rgb[4] = '{24'h0000FF, 24'h00FE01, 24'h01FF00, 24'hFF0100};

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.in_sof   = 1'b0;
        mode         = 2'd0;
        threshold    = 8'd0;
        fg_rgb       = 24'h0;
        bg_rgb       = 24'h0;
        popped       = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_rgb", {bus.out_r, bus.out_g, bus.out_b}, 0);
        check("reset_pos", {bus.out_col, bus.out_row}, 0);
        check("reset_flags", {bus.out_sof, bus.out_eol, bus.out_eof, sync_err}, 0);
        rst = 1'b0;

        // Pin the model against hand-computed values
        check("model_heat_0", model_map(0, 2'd3, 0, 0, 0), 24'h0000FF);
        check("model_heat_128", model_map(128, 2'd3, 0, 0, 0), 24'h01FF00);
        check("model_invert", model_map(10, 2'd2, 0, 0, 0), 24'hF5F5F5);
        check("model_binary", model_map(127, 2'd1, 128, 24'hFF0000, 24'h0000FF), 24'h0000FF);

        // 1: grayscale frame at full rate
        mode = 2'd0;
        for (int k = 0; k < NPIX; k++) begin
            send(8'(k), k == 0);
            if (k == 0) check("t1_first_beat", {bus.out_valid, bus.out_sof}, 2'b11);
            if (k == 9) check("t1_eol9", {bus.out_eol, bus.out_g}, {1'b1, 8'd9});
            if (k == 99) begin
                check("t1_eof", {bus.out_eof, bus.out_b}, {1'b1, 8'd99});
                check("t1_last_pos", {bus.out_col, bus.out_row}, {4'd9, 4'd9});
            end
        end
        drain();

        // 2: binary fg/bg
        mode = 2'd1; threshold = 8'd128; fg_rgb = 24'hFF0000; bg_rgb = 24'h0000FF;
        send(8'd127, 1'b1);
        check("t2_127", {bus.out_r, bus.out_g, bus.out_b}, 24'h0000FF);
        send(8'd128, 1'b0);
        check("t2_128", {bus.out_r, bus.out_g, bus.out_b}, 24'hFF0000);
        for (int k = 2; k < NPIX; k++) send(8'((k * 37) % 256), 1'b0);
        drain();

        // 3: heat map
        mode = 2'd3;
        for (int k = 0; k < 4; k++) begin
            send(heat_p[k], k == 0);
            check("t3_heat", {bus.out_r, bus.out_g, bus.out_b}, heat_rgb[k]);
        end
        for (int k = 4; k < NPIX; k++) send(8'(k * 3), 1'b0);
        drain();

        // 4: random downstream stalls
        mode = 2'd0;
        stall_en = 1'b1;
        popped = 0;
        for (int k = 0; k < NPIX; k++) send(8'(k + 50), k == 0);
        drain();
        stall_en = 1'b0;
        check("t4_beat_count", popped, NPIX);

        // 5: mid-frame mode change is deferred to the next frame
        mode = 2'd0;
        for (int k = 0; k < NPIX; k++) begin
            if (k == 37) mode = 2'd2;
            send(8'(k), k == 0);
            if (k == 37) check("t5_mid_frame", bus.out_r, 8'd37);
        end
        send(8'd10, 1'b1);
        check("t5_next_frame", {bus.out_r, bus.out_g, bus.out_b}, 24'hF5F5F5);
        for (int k = 1; k < NPIX; k++) send(8'(k), 1'b0);
        drain();

        // 6: resync on unexpected in_sof, then reset mid-frame
        mode = 2'd0;
        for (int k = 0; k < 45; k++) send(8'(k), k == 0);
        send(8'd45, 1'b1);
        check("t6_resync_beat", {bus.out_sof, bus.out_col, bus.out_row, sync_err},
              {1'b1, 4'd0, 4'd0, 1'b1});
        send(8'd46, 1'b0);
        check("t6_after_resync", {bus.out_col, sync_err}, {4'd1, 1'b0});
        for (int k = 47; k < 145; k++) send(8'(k), 1'b0);
        for (int k = 0; k < 30; k++) send(8'(k), k == 0);
        rst = 1'b1;
        #1;
        check("t6_rst_clears", {bus.out_valid, bus.out_sof, bus.out_col}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd7, 1'b0);
        check("t6_post_rst_pos", {bus.out_sof, bus.out_col, bus.out_row}, {1'b1, 4'd0, 4'd0});
        check("t6_missing_sof", sync_err, 1);
        send(8'd8, 1'b0);
        check("t6_post_rst_next", {bus.out_col, sync_err}, {4'd1, 1'b0});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
